// File: rtl/my_rr_arb4.sv
// Four-way round-robin arbiter driving the select of my_mux4way16 with a valid/ready
// handshake. Define MY_RR_ARB_BURST_EN to let a winner keep the grant for up to BURST_LEN accepts.
module my_rr_arb4 #(
    parameter int BURST_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       ready,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       valid,
    output logic [3:0] ack
);

    if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_burst_len_bad
        $error("my_rr_arb4: BURST_LEN must be in 1..15");
    end

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state, state_n;
    logic [1:0] ptr, ptr_n, sel_n, ptr_rot;
    logic [3:0] grant_n;
    logic       valid_n;
    logic       accept, abort, stay, take;
    logic [2:0] pick, pick_idle, pick_rot;

`ifdef MY_RR_ARB_BURST_EN
    logic [3:0] cnt, cnt_n;
`endif

    // Returns {found, index}; the index closest to start (with wrap) wins.
    function automatic logic [2:0] rr_pick(input logic [1:0] start, input logic [3:0] r);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = start + 2'(k);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 2'b00;
            sel   <= 2'b00;
            grant <= 4'b0000;
            valid <= 1'b0;
`ifdef MY_RR_ARB_BURST_EN
            cnt   <= 4'd0;
`endif
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            grant <= grant_n;
            valid <= valid_n;
`ifdef MY_RR_ARB_BURST_EN
            cnt   <= cnt_n;
`endif
        end
    end

    always_comb begin
        accept    = valid & ready;
        abort     = valid & ~ready & ~req[sel];
        ptr_rot   = sel + 2'd1;
        pick_idle = rr_pick(ptr, req);
        // The channel just served is masked so it cannot win straight back.
        pick_rot  = rr_pick(ptr_rot, req & ~grant);
`ifdef MY_RR_ARB_BURST_EN
        stay      = req[sel] && ((5'(cnt) + 5'd1) < 5'(BURST_LEN));
        cnt_n     = cnt;
`else
        stay      = 1'b0;
`endif
        state_n   = state;
        ptr_n     = ptr;
        sel_n     = sel;
        grant_n   = grant;
        valid_n   = valid;
        take      = 1'b0;
        pick      = pick_idle;

        case (state)
            IDLE: begin
                take = 1'b1;
            end
            GRANT: begin
                if (accept) begin
                    if (stay) begin
`ifdef MY_RR_ARB_BURST_EN
                        cnt_n = cnt + 4'd1;
`endif
                    end else begin
                        ptr_n = ptr_rot;
                        take  = 1'b1;
                        pick  = pick_rot;
`ifdef MY_RR_ARB_BURST_EN
                        cnt_n = 4'd0;
`endif
                    end
                end else if (abort) begin
                    take = 1'b1;
`ifdef MY_RR_ARB_BURST_EN
                    cnt_n = 4'd0;
`endif
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (take) begin
            if (pick[2]) begin
                state_n = GRANT;
                sel_n   = pick[1:0];
                grant_n = 4'b0001 << pick[1:0];
                valid_n = 1'b1;
            end else begin
                state_n = IDLE;
                grant_n = 4'b0000;
                valid_n = 1'b0;
            end
        end
    end

    always_comb begin
        ack = grant & {4{valid & ready}};
    end

endmodule

// File: tb/tb_my_rr_arb4.sv
// Scoreboard bench for my_rr_arb4: stimulus queues the expected winner of each accepted
// transfer, a negedge monitor checks every accept (and that ack stays low otherwise).
module tb_my_rr_arb4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ready;
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] grant;
    logic [3:0] ack;
    logic       valid;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] oh;
    } exp_t;

    exp_t sb[$];

`ifdef MY_RR_ARB_BURST_EN
    localparam int BL = 3;
`else
    localparam int BL = 4;
`endif

    my_rr_arb4 #(.BURST_LEN(BL)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .ready (ready),
        .sel   (sel),
        .grant (grant),
        .valid (valid),
        .ack   (ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] s);
        exp_t e;
        e.sel = s;
        e.oh  = 4'b0001 << s;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        ready = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // n back-to-back accepts with ready held high, then drain to idle
    task automatic run(input logic [3:0] r, input int n);
        req   = r;
        ready = 1'b1;
        repeat (n) step();
        @(negedge clk);
        #1;
        req   = 4'b0000;
        ready = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("run_drain_valid", 8'(valid), 8'h00);
    endtask

    task automatic chk_out(input string name, input logic [1:0] s, input logic [3:0] g, input logic v);
        chk({name, "_sel"}, 8'(sel), 8'(s));
        chk({name, "_grant"}, 8'(grant), 8'(g));
        chk({name, "_valid"}, 8'(valid), 8'(v));
    endtask

    // Monitor: every accept must match the next scoreboard entry
    always @(negedge clk) begin
        if (!reset) begin
            if (valid && ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_accept: sel=%0d ack=%b expected no accept", sel, ack);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("accept_sel", 8'(sel), 8'(e.sel));
                    chk("accept_grant", 8'(grant), 8'(e.oh));
                    chk("accept_ack", 8'(ack), 8'(e.oh));
                end
            end else begin
                chk("ack_idle", 8'(ack), 8'h00);
            end
        end
    end

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        ready = 1'b0;
        #2;
        chk("rst_sel", 8'(sel), 8'h00);
        chk("rst_grant", 8'(grant), 8'h00);
        chk("rst_valid", 8'(valid), 8'h00);
        chk("rst_ack", 8'(ack), 8'h00);

        // ready while idle is ignored
        do_reset();
        ready = 1'b1;
        step();
        step();
        @(negedge clk);
        chk_out("idle_ready", 2'b00, 4'b0000, 1'b0);

        // single requester: 1-cycle latency, hold 5 cycles, single ack
        do_reset();
        req = 4'b0100;
        step();
        @(negedge clk);
        chk_out("single_first", 2'b10, 4'b0100, 1'b1);
        repeat (5) begin
            step();
            @(negedge clk);
            chk_out("single_hold", 2'b10, 4'b0100, 1'b1);
        end
        step();
        push(2'b10);
        ready = 1'b1;
        step();
        req   = 4'b0000;
        ready = 1'b0;
        @(negedge clk);
        chk("single_after_valid", 8'(valid), 8'h00);

        // asynchronous reset in the middle of a grant
        do_reset();
        req = 4'b0100;
        step();
        @(negedge clk);
        chk("midrst_pre_sel", 8'(sel), 8'h02);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_sel", 8'(sel), 8'h00);
        chk("midrst_grant", 8'(grant), 8'h00);
        chk("midrst_valid", 8'(valid), 8'h00);
        chk("midrst_ack", 8'(ack), 8'h00);
        req = 4'b0000;
        step();
        reset = 1'b0;
        step();
        @(negedge clk);
        chk_out("midrst_after", 2'b00, 4'b0000, 1'b0);

        // full round robin
        do_reset();
        push(2'd0); push(2'd1); push(2'd2); push(2'd3); push(2'd0);
        run(4'b1111, 5);

        // wrap and skip
        do_reset();
        push(2'd0); push(2'd3); push(2'd0); push(2'd3);
        run(4'b1001, 4);

        // abort: requester drops before being accepted
        do_reset();
        req = 4'b0010;
        step();
        @(negedge clk);
        chk_out("abort_grant", 2'b01, 4'b0010, 1'b1);
        step();
        req = 4'b0000;
        step();
        @(negedge clk);
        chk("abort_valid", 8'(valid), 8'h00);
        chk("abort_grant0", 8'(grant), 8'h00);
        step();
        req = 4'b0011;
        step();
        @(negedge clk);
        chk_out("abort_regrant", 2'b00, 4'b0001, 1'b1);
        step();
        req = 4'b0000;
        step();
        step();

        // burst / plain alternation between two requesters
        do_reset();
`ifdef MY_RR_ARB_BURST_EN
        push(2'd0); push(2'd0); push(2'd0);
        push(2'd1); push(2'd1); push(2'd1);
        push(2'd0);
        run(4'b0011, 7);
`else
        push(2'd0); push(2'd1); push(2'd0); push(2'd1);
        run(4'b0011, 4);
`endif

        chk("scoreboard_drained", 8'(sb.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
